// File: rtl/led_matrix_pwm.sv
// rtl/led_matrix_pwm.sv - multiplexed LED matrix driver with per-LED PWM and tear-free double buffering
module led_matrix_pwm #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int PWM_BITS = 4,
    parameter int SCAN_DIV = 32,
    parameter int BLANK    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ROWS*COLS*PWM_BITS-1:0] led_level,
    input  logic                         load,
    output logic [COLS-1:0]              aled,
    output logic [ROWS-1:0]              kled_tri,
    output logic                         frame_start,
    output logic                         pending
);
    localparam int N   = ROWS * COLS;
    localparam int LW  = N * PWM_BITS;
    localparam int CW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW  = (N > 1) ? $clog2(N) : 1;
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int KW  = (COLS > 1) ? $clog2(COLS) : 1;

    logic [CW-1:0]       cyc;
    logic [SW-1:0]       slot;
    logic [RW-1:0]       row;
    logic [KW-1:0]       col;
    logic [PWM_BITS-1:0] phase;
    logic [LW-1:0]       active_buf;
    logic [LW-1:0]       pending_buf;

    logic                cyc_last;
    logic                slot_last;
    logic                col_last;
    logic                row_last;
    logic                boundary;
    logic                blanking;
    logic [PWM_BITS-1:0] level;
    logic                lit;

    assign cyc_last  = (cyc == CW'(SCAN_DIV - 1));
    assign slot_last = (slot == SW'(N - 1));
    assign col_last  = (col == KW'(COLS - 1));
    assign row_last  = (row == RW'(ROWS - 1));
    assign boundary  = cyc_last && slot_last;
    assign blanking  = ({1'b0, cyc} < (CW+1)'(BLANK));
    assign level     = active_buf[slot*PWM_BITS +: PWM_BITS];
    assign lit       = (level > phase);

    // Row/column are tracked alongside slot so no divider is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc   <= '0;
            slot  <= '0;
            row   <= '0;
            col   <= '0;
            phase <= '0;
        end else begin
            cyc <= cyc_last ? '0 : cyc + 1'b1;
            if (cyc_last) begin
                slot <= slot_last ? '0 : slot + 1'b1;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (slot_last) begin
                    phase <= phase + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aled        <= '1;
            kled_tri    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (slot == '0) && (cyc == '0);
            if (blanking) begin
                aled     <= '1;
                kled_tri <= '0;
            end else begin
                aled     <= ~(COLS'(1) << col);
                kled_tri <= lit ? (ROWS'(1) << row) : '0;
            end
        end
    end

    // The displayed buffer only ever changes on the last cycle of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_buf  <= '0;
            pending_buf <= '0;
            pending     <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                active_buf <= led_level;
                pending    <= 1'b0;
            end else if (pending) begin
                active_buf <= pending_buf;
                pending    <= 1'b0;
            end
        end else if (load) begin
            pending_buf <= led_level;
            pending     <= 1'b1;
        end
    end
endmodule

// File: tb/tb_led_matrix_pwm.sv
// tb/tb_led_matrix_pwm.sv - self-checking bench for led_matrix_pwm against a cycle-count reference model
module tb_led_matrix_pwm;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int PB    = 4;
    localparam int SD    = 32;
    localparam int BLANK = 2;
    localparam int N     = ROWS * COLS;
    localparam int LW    = N * PB;
    localparam int FRAME = SD * N;
    localparam int LEVELS = 1 << PB;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [LW-1:0]   led_level = '0;
    logic            load = 1'b0;
    logic [COLS-1:0] aled;
    logic [ROWS-1:0] kled_tri;
    logic            frame_start;
    logic            pending;

    int checks = 0;
    int failures = 0;

    led_matrix_pwm #(.ROWS(ROWS), .COLS(COLS), .PWM_BITS(PB), .SCAN_DIV(SD), .BLANK(BLANK)) dut (
        .clk(clk), .rst(rst), .led_level(led_level), .load(load),
        .aled(aled), .kled_tri(kled_tri), .frame_start(frame_start), .pending(pending)
    );

    always #5 clk = ~clk;

    // Reference model: t counts clocks since reset; display position is plain arithmetic on t.
    int            t = 0;
    logic [LW-1:0] m_active = '0;
    logic [LW-1:0] m_pend = '0;
    logic          m_pflag = 1'b0;
    logic [COLS-1:0] e_aled = '1;
    logic [ROWS-1:0] e_kled = '0;
    logic          e_fs = 1'b0;

    function automatic logic [COLS-1:0] f_aled(int tt);
        int c;
        c = ((tt / SD) % N) % COLS;
        if ((tt % SD) < BLANK) return '1;
        return ~(COLS'(1) << c);
    endfunction

    function automatic logic [ROWS-1:0] f_kled(int tt, logic [LW-1:0] act);
        int slot, ph, lvl;
        slot = (tt / SD) % N;
        ph   = (tt / FRAME) % LEVELS;
        lvl  = int'((act >> (slot * PB)) & LW'(LEVELS - 1));
        if ((tt % SD) < BLANK || lvl <= ph) return '0;
        return ROWS'(1) << (slot / COLS);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t <= 0; m_active <= '0; m_pend <= '0; m_pflag <= 1'b0;
            e_aled <= '1; e_kled <= '0; e_fs <= 1'b0;
        end else begin
            t      <= t + 1;
            e_fs   <= ((t % FRAME) == 0);
            e_aled <= f_aled(t);
            e_kled <= f_kled(t, m_active);
            if ((t % FRAME) == FRAME - 1) begin
                if (load) begin
                    m_active <= led_level; m_pflag <= 1'b0;
                end else if (m_pflag) begin
                    m_active <= m_pend; m_pflag <= 1'b0;
                end
            end else if (load) begin
                m_pend <= led_level; m_pflag <= 1'b1;
            end
        end
    end

    task automatic do_reset(int cycles);
        @(negedge clk); rst = 1'b1; load = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_at(int offset, logic [LW-1:0] val);
        int guard = 0;
        while ((t % FRAME) != offset && guard < 2 * FRAME) begin
            @(negedge clk); guard++;
        end
        led_level = val; load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk); rst = 1'b1; load = 1'b1; led_level = '1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (aled !== 4'b1111) begin failures++; $display("FAIL reset_aled got=%b want=1111", aled); end
        checks++; if (kled_tri !== 4'b0000) begin failures++; $display("FAIL reset_kled got=%b want=0000", kled_tri); end
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b want=0", pending); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b want=0", frame_start); end
        @(negedge clk); rst = 1'b0; load = 1'b0;
        for (int i = 1; i <= 1100; i++) begin
            @(posedge clk); #1;
            checks++;
            if (frame_start !== ((i % FRAME) == 1)) begin
                failures++; $display("FAIL fs_after_reset clk=%0d got=%b want=%b", i, frame_start, (i % FRAME) == 1);
            end
            checks++;
            if (kled_tri !== '0 || pending !== 1'b0) begin
                failures++; $display("FAIL dark_after_reset clk=%0d kled=%b pending=%b want 0/0", i, kled_tri, pending);
            end
        end
    endtask

    task automatic test_full_on;
        int cnt [N];
        int tp;
        logic exp_p;
        foreach (cnt[k]) cnt[k] = 0;
        load_at(200, '1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk); #1;
            exp_p = ((t - 1) % FRAME) != FRAME - 1;
            checks++;
            if (pending !== exp_p) begin failures++; $display("FAIL full_pending got=%b want=%b", pending, exp_p); end
            if (!exp_p) break;
        end
        for (int i = 0; i < LEVELS * FRAME; i++) begin
            @(posedge clk); #1;
            tp = t - 1;
            for (int k = 0; k < N; k++)
                if (kled_tri[k / COLS] && !aled[k % COLS]) cnt[k]++;
            if ((tp % SD) < BLANK) begin
                checks++;
                if (kled_tri !== '0) begin failures++; $display("FAIL full_blank cyc=%0d got=%b want=0000", tp % SD, kled_tri); end
            end
            checks++;
            if (kled_tri !== e_kled || aled !== e_aled) begin
                failures++; $display("FAIL full_model kled=%b/%b aled=%b/%b (got/want)", kled_tri, e_kled, aled, e_aled);
            end
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (cnt[k] != (LEVELS - 1) * (SD - BLANK)) begin
                failures++; $display("FAIL full_lit_count led=%0d got=%0d want=%0d", k, cnt[k], (LEVELS - 1) * (SD - BLANK));
            end
        end
    endtask

    task automatic test_single_led;
        logic [LW-1:0] v;
        int tp, slot, cyc, ph;
        logic on;
        v = '0; v[5*PB +: PB] = 4'h8;
        load_at(40, v);
        while ((t % FRAME) != 0) @(negedge clk);
        for (int i = 0; i < LEVELS * FRAME; i++) begin
            @(posedge clk); #1;
            tp = t - 1; slot = (tp / SD) % N; cyc = tp % SD; ph = (tp / FRAME) % LEVELS;
            on = (slot == 5) && (cyc >= BLANK) && (ph < 8);
            checks++;
            if (kled_tri !== (on ? 4'b0010 : 4'b0000)) begin
                failures++; $display("FAIL led5_kled slot=%0d cyc=%0d ph=%0d got=%b want=%b", slot, cyc, ph, kled_tri, on ? 4'b0010 : 4'b0000);
            end
            if (slot == 5 && cyc >= BLANK) begin
                checks++;
                if (aled !== 4'b1101) begin failures++; $display("FAIL led5_aled got=%b want=1101", aled); end
            end
        end
    endtask

    task automatic test_last_write_wins;
        logic [LW-1:0] b;
        int lit_cnt, ph;
        b = '0; b[0 +: PB] = 4'hF;
        do_reset(2);
        load_at(100, '1);
        load_at(300, b);
        checks++; if (pending !== 1'b1) begin failures++; $display("FAIL lww_pending got=%b want=1", pending); end
        while ((t % FRAME) != 0) begin
            @(posedge clk); #1;
            checks++; if (kled_tri !== '0) begin failures++; $display("FAIL lww_frame1_dark got=%b want=0000", kled_tri); end
        end
        ph = (t / FRAME) % LEVELS;
        lit_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk); #1;
            if (kled_tri != '0) begin
                lit_cnt++;
                checks++;
                if (kled_tri !== 4'b0001 || aled !== 4'b1110) begin
                    failures++; $display("FAIL lww_only_b kled=%b aled=%b want 0001/1110", kled_tri, aled);
                end
            end
        end
        checks++;
        if (lit_cnt != ((15 > ph) ? SD - BLANK : 0)) begin
            failures++; $display("FAIL lww_lit_count got=%0d want=%0d", lit_cnt, (15 > ph) ? SD - BLANK : 0);
        end
    endtask

    task automatic test_boundary_load;
        logic [LW-1:0] c;
        int lit_cnt, ph;
        c = '0; c[3*PB +: PB] = 4'hF;
        load_at(50, '1);
        checks++; if (pending !== 1'b1) begin failures++; $display("FAIL bnd_pending_d got=%b want=1", pending); end
        while ((t % FRAME) != FRAME - 1) @(negedge clk);
        led_level = c; load = 1'b1;
        @(posedge clk); #1;
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL bnd_pending_clr got=%b want=0", pending); end
        @(negedge clk); load = 1'b0; led_level = '1;
        ph = ((t - 1) / FRAME) % LEVELS;
        lit_cnt = 0;
        for (int i = 0; i < FRAME - 1; i++) begin
            @(posedge clk); #1;
            if (kled_tri != '0) begin
                lit_cnt++;
                checks++;
                if (kled_tri !== 4'b0001 || aled !== 4'b0111) begin
                    failures++; $display("FAIL bnd_only_c kled=%b aled=%b want 0001/0111", kled_tri, aled);
                end
            end
        end
        checks++;
        if (lit_cnt != ((15 > ph) ? SD - BLANK : 0)) begin
            failures++; $display("FAIL bnd_lit_count got=%0d want=%0d", lit_cnt, (15 > ph) ? SD - BLANK : 0);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 799) == 0);
            load = ($urandom_range(0, 29) == 0);
            led_level = {$urandom, $urandom};
            @(posedge clk); #1;
            checks++;
            if (aled !== e_aled || kled_tri !== e_kled || frame_start !== e_fs || pending !== m_pflag) begin
                failures++;
                $display("FAIL rand_model i=%0d aled=%b/%b kled=%b/%b fs=%b/%b pend=%b/%b (got/want)",
                         i, aled, e_aled, kled_tri, e_kled, frame_start, e_fs, pending, m_pflag);
            end
            checks++;
            if ($countones(kled_tri) > 1 || $countones(~aled) > 1) begin
                failures++; $display("FAIL rand_onehot kled=%b aled=%b want at most one active", kled_tri, aled);
            end
        end
        @(negedge clk); rst = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset;
        test_full_on;
        test_single_led;
        test_last_write_wins;
        test_boundary_load;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
